mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_load_extend.sv | 31 +++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared access-size and sequencer-state encodings for the MEM stage
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DUMP  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_half(input logic [1:0] bhw);
      return bhw == SZ_HALF;
   endfunction

   // Encoding 2'b10 is not a legal size and behaves as a word access.
   function automatic logic is_word(input logic [1:0] bhw);
      return bhw[1];
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// rtl/mem_stage_load_extend.sv - lane select plus sign/zero extension of a little-endian memory word
module load_extend
   import mem_stage_pkg::*;
#(
   parameter int INST_SZ = 32
) (
   input  logic [INST_SZ-1:0] i_word,
   input  logic [1:0]         i_lane,
   input  logic [1:0]         i_bhw,
   input  logic               i_unsigned,
   output logic [INST_SZ-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_lane, 3'b000} +: 8];
   assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

   always_comb begin
      o_data = '0;
      if (is_word(i_bhw)) begin
         o_data = i_word;
      end else if (is_half(i_bhw)) begin
         o_data = {{(INST_SZ-16){~i_unsigned & w_half[15]}}, w_half};
      end else begin
         o_data = {{(INST_SZ-8){~i_unsigned & w_byte[7]}}, w_byte};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: byte-addressable data memory, zero-fill after reset, debug dump port
// Optional misalignment trap: define MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int INST_SZ    = 32,
   parameter int MEM_ADDR_W = 7
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [1:0]            i_bhw,
   input  logic                  i_unsigned,
   input  logic [INST_SZ-1:0]    i_addr,
   input  logic [INST_SZ-1:0]    i_write_data,
   output logic [INST_SZ-1:0]    o_read_data,
   output logic                  o_busy,
   output logic                  o_misaligned,
   input  logic                  i_dump_start,
   output logic                  o_dump_valid,
   input  logic                  i_dump_ready,
   output logic [MEM_ADDR_W-1:0] o_dump_addr,
   output logic [INST_SZ-1:0]    o_dump_data,
   output logic                  o_dump_done
);

   localparam int DEPTH = 2 ** MEM_ADDR_W;
   localparam logic [MEM_ADDR_W-1:0] LAST_IDX = {MEM_ADDR_W{1'b1}};

   logic [INST_SZ-1:0]    r_mem [DEPTH];
   state_t                r_state;
   logic [MEM_ADDR_W-1:0] r_ptr;
   logic                  r_dump_valid;
   logic                  r_dump_done;

   logic [MEM_ADDR_W-1:0] w_idx;
   logic [1:0]            w_lane;
   logic                  w_access;
   logic                  w_misaligned;
   logic                  w_store;
   logic [INST_SZ-1:0]    w_rd_word;
   logic [INST_SZ-1:0]    w_ext;
   logic [3:0]            w_be;
   logic [INST_SZ-1:0]    w_mask;
   logic [INST_SZ-1:0]    w_wdata;
   logic [INST_SZ-1:0]    w_merged;
   logic                  w_unused;

   // Address bits above the memory depth wrap silently.
   assign w_unused = &{1'b0, i_addr[INST_SZ-1:MEM_ADDR_W+2]};
   assign w_idx    = i_addr[MEM_ADDR_W+1:2];
   assign w_access = i_mem_read | i_mem_write;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign w_lane       = i_addr[1:0];
   assign w_misaligned = (r_state == ST_IDLE) && w_access &&
                         ((is_half(i_bhw) && i_addr[0]) ||
                          (is_word(i_bhw) && (i_addr[1:0] != 2'b00)));
`else
   // Without the trap, offending low bits are dropped to the natural boundary.
   assign w_lane       = is_word(i_bhw) ? 2'b00 :
                         is_half(i_bhw) ? {i_addr[1], 1'b0} : i_addr[1:0];
   assign w_misaligned = 1'b0;
`endif

   assign w_rd_word = r_mem[w_idx];

   load_extend #(
      .INST_SZ (INST_SZ)
   ) u_load_extend (
      .i_word     (w_rd_word),
      .i_lane     (w_lane),
      .i_bhw      (i_bhw),
      .i_unsigned (i_unsigned),
      .o_data     (w_ext)
   );

   assign o_read_data = ((r_state == ST_IDLE) && !w_misaligned) ? w_ext : '0;

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = i_write_data;
      if (is_word(i_bhw)) begin
         w_be    = 4'b1111;
      end else if (is_half(i_bhw)) begin
         w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{i_write_data[15:0]}};
      end else begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{i_write_data[7:0]}};
      end
   end

   always_comb begin
      w_mask = '0;
      for (int b = 0; b < 4; b++) begin
         w_mask[8*b +: 8] = {8{w_be[b]}};
      end
   end

   assign w_merged = (w_rd_word & ~w_mask) | (w_wdata & w_mask);
   assign w_store  = (r_state == ST_IDLE) && i_enable && i_mem_write && !w_misaligned;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_CLEAR;
         r_ptr        <= '0;
         r_dump_valid <= 1'b0;
         r_dump_done  <= 1'b0;
      end else begin
         r_dump_done <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               r_mem[r_ptr] <= '0;
               r_ptr        <= r_ptr + 1'b1;
               if (r_ptr == LAST_IDX) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= '0;
               end
            end
            ST_IDLE: begin
               if (w_store) begin
                  r_mem[w_idx] <= w_merged;
               end
               // A dump is only honoured while the pipeline is halted.
               if (i_dump_start && !i_enable) begin
                  r_state      <= ST_DUMP;
                  r_ptr        <= '0;
                  r_dump_valid <= 1'b1;
               end
            end
            ST_DUMP: begin
               if (r_dump_valid && i_dump_ready) begin
                  if (r_ptr == LAST_IDX) begin
                     r_state      <= ST_DONE;
                     r_ptr        <= '0;
                     r_dump_valid <= 1'b0;
                     r_dump_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_CLEAR;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   assign o_busy       = (r_state != ST_IDLE);
   assign o_misaligned = w_misaligned;
   assign o_dump_valid = r_dump_valid;
   assign o_dump_addr  = r_ptr;
   assign o_dump_data  = r_mem[r_ptr];
   assign o_dump_done  = r_dump_done;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage against a byte-array reference model
module tb_mem_stage;

   localparam int XW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 128;

   logic          i_clk;
   logic          i_reset;
   logic          i_enable;
   logic          i_mem_read;
   logic          i_mem_write;
   logic [1:0]    i_bhw;
   logic          i_unsigned;
   logic [XW-1:0] i_addr;
   logic [XW-1:0] i_write_data;
   logic [XW-1:0] o_read_data;
   logic          o_busy;
   logic          o_misaligned;
   logic          i_dump_start;
   logic          o_dump_valid;
   logic          i_dump_ready;
   logic [AW-1:0] o_dump_addr;
   logic [XW-1:0] o_dump_data;
   logic          o_dump_done;

   mem_stage #(.INST_SZ(XW), .MEM_ADDR_W(AW)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_mem_read   (i_mem_read),
      .i_mem_write  (i_mem_write),
      .i_bhw        (i_bhw),
      .i_unsigned   (i_unsigned),
      .i_addr       (i_addr),
      .i_write_data (i_write_data),
      .o_read_data  (o_read_data),
      .o_busy       (o_busy),
      .o_misaligned (o_misaligned),
      .i_dump_start (i_dump_start),
      .o_dump_valid (o_dump_valid),
      .i_dump_ready (i_dump_ready),
      .o_dump_addr  (o_dump_addr),
      .o_dump_data  (o_dump_data),
      .o_dump_done  (o_dump_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          has_load;
      logic [31:0] data;
      bit          mis;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } dw_t;

   exp_t        exp_q[$];
   dw_t         dump_q[$];
   logic [7:0]  mb [512];
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   int          done_cnt = 0;
   bit          hold     = 0;
   logic [31:0] hold_a;
   logic [31:0] hold_d;
   logic [31:0] last_acc = 32'hFFFF_FFFF;
   exp_t        mon_e;
   dw_t         mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      chk_cnt++;
      if (act === exp_v) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
   endtask

   function automatic int sz_of(input logic [1:0] bhw);
      if (bhw == 2'b00) return 1;
      if (bhw == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit model_mis(input logic [31:0] a, input logic [1:0] bhw);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      return (int'(a[1:0]) % sz_of(bhw)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int base_of(input logic [31:0] a, input logic [1:0] bhw);
      int ba;
      ba = int'(a[8:0]);
      return ba - (ba % sz_of(bhw));
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] bhw, input bit uns);
      logic [31:0] v;
      int sz;
      int b;
      if (model_mis(a, bhw)) return 32'h0;
      sz = sz_of(bhw);
      b  = base_of(a, bhw);
      v  = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[b+i]) << (8*i));
      if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] bhw, input logic [31:0] wd);
      int b;
      if (model_mis(a, bhw)) return;
      b = base_of(a, bhw);
      for (int i = 0; i < sz_of(bhw); i++) mb[b+i] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] model_word(input int idx);
      return {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 512; i++) mb[i] = 8'h00;
   endtask

   task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] bhw,
                     input bit uns, input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_v);
      exp_t e;
      i_mem_read   = rd;
      i_mem_write  = wr;
      i_addr       = a;
      i_bhw        = bhw;
      i_unsigned   = uns;
      i_write_data = wd;
      if (rd || wr) begin
         e.has_load = rd;
         e.data     = use_exp ? exp_v : model_load(a, bhw, uns);
         e.mis      = model_mis(a, bhw);
         exp_q.push_back(e);
      end
      if (wr) model_store(a, bhw, wd);
      @(posedge i_clk); #1;
      i_mem_read  = 1'b0;
      i_mem_write = 1'b0;
   endtask

   task automatic push_dump();
      dw_t w;
      for (int i = 0; i < DEPTH; i++) begin
         w.a = 32'(i);
         w.d = model_word(i);
         dump_q.push_back(w);
      end
   endtask

   task automatic wait_clear(input string name);
      int cnt;
      cnt = 0;
      while (o_busy && cnt < 1000) begin
         @(posedge i_clk); #1;
         cnt++;
      end
      check(name, 32'(cnt), 32'(DEPTH));
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a load/store result or a dump word.
   always @(negedge i_clk) begin
      if (!i_reset && !o_busy && (i_mem_read || i_mem_write)) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_empty: access at addr %h with nothing expected", i_addr);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.has_load) check("load_data", o_read_data, mon_e.data);
            check("misaligned", 32'(o_misaligned), 32'(mon_e.mis));
         end
      end
      if (o_dump_valid) begin
         if (hold) begin
            check("dump_stable_addr", 32'(o_dump_addr), hold_a);
            check("dump_stable_data", o_dump_data, hold_d);
         end
         if (i_dump_ready) begin
            if (dump_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL dump_unexpected: got addr %h expected no word", o_dump_addr);
            end else begin
               mon_d = dump_q.pop_front();
               check("dump_addr", 32'(o_dump_addr), mon_d.a);
               check("dump_data", o_dump_data, mon_d.d);
            end
            last_acc = 32'(o_dump_addr);
            hold     = 1'b0;
         end else begin
            hold   = 1'b1;
            hold_a = 32'(o_dump_addr);
            hold_d = o_dump_data;
         end
      end else begin
         hold = 1'b0;
      end
      if (o_dump_done) begin
         done_cnt++;
         check("done_after_last", last_acc, 32'(DEPTH-1));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          k;
      int          cyc;

      i_reset = 1'b1; i_enable = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_bhw = 2'b11; i_unsigned = 1'b0; i_addr = '0; i_write_data = '0;
      i_dump_start = 1'b0; i_dump_ready = 1'b0;
      model_clear();

      // Reset state, with a misaligned read presented so the flag's gating is exercised.
      i_mem_read = 1'b1; i_addr = 32'h6;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_busy", 32'(o_busy), 32'd1);
      check("rst_dump_valid", 32'(o_dump_valid), 32'd0);
      check("rst_dump_done", 32'(o_dump_done), 32'd0);
      check("rst_misaligned", 32'(o_misaligned), 32'd0);
      check("rst_read_data", o_read_data, 32'd0);
      i_mem_read = 1'b0;
      i_reset    = 1'b0;
      wait_clear("clear_cycles");

      i_enable = 1'b1;
      for (int i = 0; i < DEPTH; i++) op(1, 0, 32'(i*4), 2'b11, 0, 0, 1, 32'h0);

      op(0, 1, 32'h10, 2'b11, 0, 32'h8899AABC, 0, 0);
      op(1, 0, 32'h10, 2'b00, 0, 0, 1, 32'hFFFFFFBC);
      op(1, 0, 32'h13, 2'b00, 1, 0, 1, 32'h00000088);
      op(1, 0, 32'h12, 2'b01, 0, 0, 1, 32'hFFFF8899);
      op(1, 0, 32'h10, 2'b01, 1, 0, 1, 32'h0000AABC);
      op(0, 1, 32'h11, 2'b00, 0, 32'h0000005A, 0, 0);
      op(1, 0, 32'h10, 2'b11, 0, 0, 1, 32'h88995ABC);
      op(1, 0, 32'h0C, 2'b11, 0, 0, 1, 32'h0);
      op(1, 0, 32'h14, 2'b11, 0, 0, 1, 32'h0);
      // Store and load to the same word in one cycle: the load sees the old contents.
      op(1, 1, 32'h10, 2'b11, 0, 32'h11223344, 1, 32'h88995ABC);
      op(1, 0, 32'h10, 2'b11, 0, 0, 1, 32'h11223344);
      op(0, 1, 32'h06, 2'b11, 0, 32'hCAFEF00D, 0, 0);
      op(1, 0, 32'h04, 2'b11, 0, 0, 0, 0);
      op(1, 0, 32'h06, 2'b11, 0, 0, 0, 0);
      op(1, 0, 32'h05, 2'b01, 1, 0, 0, 0);
      op(1, 0, 32'h10, 2'b10, 0, 0, 1, 32'h11223344);

      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         if (n % 2 == 0) a = (a & 32'hFFFF_FE00) | (a & 32'h0000_003F);
         k = $urandom_range(0, 3);
         op(k != 1, k == 1 || k == 2, a, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            $urandom, 0, 0);
      end
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      // Full dump with random back-pressure; enable rises mid-dump with a store that must be ignored.
      @(posedge i_clk); #1;
      i_enable = 1'b0;
      push_dump();
      i_dump_start = 1'b1;
      @(posedge i_clk); #1;
      i_dump_start = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < 5000) begin
         i_dump_ready = bit'($urandom_range(0, 1));
         if (cyc == 40) begin
            i_enable = 1'b1;
            i_mem_write = 1'b1; i_addr = 32'h20; i_bhw = 2'b11; i_write_data = 32'hDEADBEEF;
         end else begin
            i_mem_write = 1'b0;
         end
         @(posedge i_clk); #1;
         cyc++;
      end
      i_mem_write  = 1'b0;
      i_dump_ready = 1'b0;
      check("dump_done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (4) @(posedge i_clk);
      #1;
      check("dump_done_once", 32'(done_cnt), 32'd1);
      check("dump_q_drained", 32'(dump_q.size()), 32'd0);
      check("idle_after_dump", 32'(o_busy), 32'd0);
      op(1, 0, 32'h20, 2'b11, 0, 0, 0, 0);

      // Dump request while the pipeline runs is ignored.
      i_dump_start = 1'b1;
      @(posedge i_clk); #1;
      i_dump_start = 1'b0;
      check("dump_ignored_busy", 32'(o_busy), 32'd0);
      check("dump_ignored_valid", 32'(o_dump_valid), 32'd0);

      // Reset in the middle of a dump restarts the zero fill.
      op(0, 1, 32'h10, 2'b11, 0, 32'h12345678, 0, 0);
      op(0, 1, 32'h1FC, 2'b11, 0, 32'hA5A5A5A5, 0, 0);
      i_enable = 1'b0;
      push_dump();
      i_dump_ready = 1'b1;
      i_dump_start = 1'b1;
      @(posedge i_clk); #1;
      i_dump_start = 1'b0;
      cyc = 0;
      while (!(o_dump_valid && o_dump_addr == 7'd5) && cyc < 200) begin
         @(posedge i_clk); #1;
         cyc++;
      end
      check("dump_reached_5", 32'(o_dump_addr), 32'd5);
      i_reset = 1'b1;
      i_mem_read = 1'b1; i_addr = 32'h10; i_bhw = 2'b11;
      @(posedge i_clk); #1;
      check("rst_mid_dump_valid", 32'(o_dump_valid), 32'd0);
      check("rst_mid_dump_busy", 32'(o_busy), 32'd1);
      check("rst_mid_dump_rdata", o_read_data, 32'd0);
      i_reset = 1'b0;
      i_mem_read = 1'b0;
      i_dump_ready = 1'b0;
      dump_q.delete();
      model_clear();
      wait_clear("reclear_cycles");
      i_enable = 1'b1;
      op(1, 0, 32'h10, 2'b11, 0, 0, 1, 32'h0);
      op(1, 0, 32'h1FC, 2'b11, 0, 0, 1, 32'h0);
      op(1, 0, 32'h20, 2'b11, 0, 0, 1, 32'h0);
      for (int n = 0; n < 40; n++) begin
         op(1, bit'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), $urandom, 0, 0);
      end
      check("final_exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
